exec_alu_arbiter: RTL and testbench

//  Shares one execute-stage ALU between two requesters: port 0 (instruction ops)
//  and port 1 (branch/jump target adds, PC + sign_ext).
//  - Round-robin arbitration with a valid/ready handshake on each port.
//  - One registered issue stage drives the shared ALU; its result is buffered per port.
//  - Sits between decode/PC logic and the single ALU instance; the ALU stays combinational.

---
 rtl/exec_alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_exec_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_arbiter
// Purpose  : Round-robin arbiter sharing one combinational execute ALU between
//            an instruction port (0) and a branch-target port (1). A single
//            registered issue stage drives the ALU; each port owns a one-deep
//            response buffer. Optional tie statistics under EXEC_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu_arbiter #(
  parameter int   WIDTH      = 16,
  parameter logic RESET_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [WIDTH-1:0] p0_A,
  input  logic [WIDTH-1:0] p0_B,
  input  logic [6:0]       p0_ctl,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  output logic [WIDTH-1:0] p0_rsp_out,
  output logic             p0_rsp_ofl,
  output logic             p0_rsp_z,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [WIDTH-1:0] p1_A,
  input  logic [WIDTH-1:0] p1_B,
  input  logic [6:0]       p1_ctl,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic [WIDTH-1:0] p1_rsp_out,
  output logic             p1_rsp_ofl,
  output logic             p1_rsp_z,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [6:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl,
  input  logic             alu_Z,
  output logic [15:0]      conflict_cnt
);

  // Issue stage and arbitration history
  logic             r_x_valid;
  logic             r_x_port;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [6:0]       r_alu_ctl;

  // Per-port response buffers
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_out0;
  logic [WIDTH-1:0] r_rsp_out1;
  logic [1:0]       r_rsp_ofl;
  logic [1:0]       r_rsp_z;

  logic [1:0]       w_elig;
  logic [1:0]       w_grant;

  // A port may compete only when it has no op in flight and no unread result;
  // reset is folded in so ready stays low while rst is asserted.
  always_comb begin
    w_elig    = 2'b00;
    w_grant   = 2'b00;
    w_elig[0] = p0_valid & ~r_rsp_valid[0] & ~(r_x_valid & ~r_x_port) & ~flush & ~rst;
    w_elig[1] = p1_valid & ~r_rsp_valid[1] & ~(r_x_valid &  r_x_port) & ~flush & ~rst;
    case (w_elig)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign p0_ready = w_grant[0];
  assign p1_ready = w_grant[1];

  // Load the issue stage on a grant; operands hold when idle so the ALU inputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_valid    <= 1'b0;
      r_x_port     <= 1'b0;
      r_last_grant <= ~RESET_PRIO;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctl    <= 7'd0;
    end else begin
      r_x_valid <= |w_grant;
      if (|w_grant) begin
        r_x_port     <= w_grant[1];
        r_last_grant <= w_grant[1];
        r_alu_a      <= w_grant[1] ? p1_A   : p0_A;
        r_alu_b      <= w_grant[1] ? p1_B   : p0_B;
        r_alu_ctl    <= w_grant[1] ? p1_ctl : p0_ctl;
      end
    end
  end

  assign alu_A   = r_alu_a;
  assign alu_B   = r_alu_b;
  assign alu_ctl = r_alu_ctl;

  // Retire the issued op into its port's buffer; consume on rsp_ready; flush drops everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 2'b00;
      r_rsp_out0  <= '0;
      r_rsp_out1  <= '0;
      r_rsp_ofl   <= 2'b00;
      r_rsp_z     <= 2'b00;
    end else if (flush) begin
      r_rsp_valid <= 2'b00;
    end else begin
      if (r_rsp_valid[0] & p0_rsp_ready) r_rsp_valid[0] <= 1'b0;
      if (r_rsp_valid[1] & p1_rsp_ready) r_rsp_valid[1] <= 1'b0;
      if (r_x_valid) begin
        // Eligibility guarantees the target buffer is empty here.
        if (r_x_port) begin
          r_rsp_valid[1] <= 1'b1;
          r_rsp_out1     <= alu_out;
          r_rsp_ofl[1]   <= alu_ofl;
          r_rsp_z[1]     <= alu_Z;
        end else begin
          r_rsp_valid[0] <= 1'b1;
          r_rsp_out0     <= alu_out;
          r_rsp_ofl[0]   <= alu_ofl;
          r_rsp_z[0]     <= alu_Z;
        end
      end
    end
  end

  assign p0_rsp_valid = r_rsp_valid[0];
  assign p0_rsp_out   = r_rsp_out0;
  assign p0_rsp_ofl   = r_rsp_ofl[0];
  assign p0_rsp_z     = r_rsp_z[0];
  assign p1_rsp_valid = r_rsp_valid[1];
  assign p1_rsp_out   = r_rsp_out1;
  assign p1_rsp_ofl   = r_rsp_ofl[1];
  assign p1_rsp_z     = r_rsp_z[1];

`ifdef EXEC_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  // Count cycles where both ports compete; saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= 16'h0000;
    end else if ((&w_elig) && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'h0001;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exec_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_alu_arbiter
// Purpose  : Self-checking bench for exec_alu_arbiter: directed scenarios plus
//            randomized traffic against a port-ownership reference model.
//            Honors EXEC_ARB_STATS_EN for the conflict counter expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_alu_arbiter;

  localparam logic [6:0] c_ADD  = 7'b0000100;
  localparam logic [6:0] c_SADD = 7'b1000100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        p0_valid = 1'b0, p1_valid = 1'b0;
  logic        p0_ready, p1_ready;
  logic [15:0] p0_A = '0, p0_B = '0, p1_A = '0, p1_B = '0;
  logic [6:0]  p0_ctl = '0, p1_ctl = '0;
  logic        p0_rsp_valid, p1_rsp_valid;
  logic        p0_rsp_ready = 1'b0, p1_rsp_ready = 1'b0;
  logic [15:0] p0_rsp_out, p1_rsp_out;
  logic        p0_rsp_ofl, p1_rsp_ofl, p0_rsp_z, p1_rsp_z;
  logic [15:0] alu_A, alu_B, alu_out;
  logic [6:0]  alu_ctl;
  logic        alu_ofl, alu_Z;
  logic [15:0] conflict_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: which ports own an op, when it was accepted, what it yields
  logic [1:0]  m_owned;
  int          m_acc [2];
  logic [17:0] m_exp [2];
  logic        m_last;
  logic [15:0] m_cnt;
  int          cyc;
  logic [1:0]  e_elig, e_grant, e_rsp;

  exec_alu_arbiter #(.WIDTH(16), .RESET_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_A(p0_A), .p0_B(p0_B), .p0_ctl(p0_ctl),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_out(p0_rsp_out),
    .p0_rsp_ofl(p0_rsp_ofl), .p0_rsp_z(p0_rsp_z),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_A(p1_A), .p1_B(p1_B), .p1_ctl(p1_ctl),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_out(p1_rsp_out),
    .p1_rsp_ofl(p1_rsp_ofl), .p1_rsp_z(p1_rsp_z),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_Z(alu_Z),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {ofl, z, out}
  function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [6:0] ctl);
    logic [15:0] aa, bb, o;
    logic [16:0] s;
    logic        ofl;
    aa  = ctl[3] ? ~a : a;
    bb  = ctl[4] ? ~b : b;
    ofl = 1'b0;
    s   = '0;
    case (ctl[2:0])
      3'b000:  o = aa & bb;
      3'b001:  o = aa | bb;
      3'b010:  o = aa ^ bb;
      3'b011:  o = ~(aa | bb);
      3'b100: begin
        s   = {1'b0, aa} + {1'b0, bb} + {16'd0, ctl[5]};
        o   = s[15:0];
        ofl = ctl[6] ? ((aa[15] == bb[15]) && (o[15] != aa[15])) : s[16];
      end
      default: o = aa;
    endcase
    return {ofl, (o == 16'h0000), o};
  endfunction

  always_comb {alu_ofl, alu_Z, alu_out} = alu_f(alu_A, alu_B, alu_ctl);

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b0;
    p0_valid = 1'b0; p1_valid = 1'b0; p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic model_reset();
    m_owned = 2'b00; m_last = 1'b1; m_cnt = 16'h0000;
    m_acc[0] = 0; m_acc[1] = 0; m_exp[0] = '0; m_exp[1] = '0;
  endtask

  // Expected handshake view of the current cycle from port ownership rules
  task automatic model_eval();
    logic [1:0] vld;
    vld     = {p1_valid, p0_valid};
    e_elig  = vld & ~m_owned & {2{~flush}};
    if (e_elig == 2'b11) e_grant = m_last ? 2'b01 : 2'b10;
    else                 e_grant = e_elig;
    for (int n = 0; n < 2; n++) e_rsp[n] = m_owned[n] && (cyc >= m_acc[n] + 2);
  endtask

  task automatic model_commit();
    logic [1:0] rr;
    rr = {p1_rsp_ready, p0_rsp_ready};
`ifdef EXEC_ARB_STATS_EN
    if (e_elig == 2'b11 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    if (flush) begin
      m_owned = 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) if (e_rsp[n] && rr[n]) m_owned[n] = 1'b0;
      if (e_grant[0]) begin
        m_owned[0] = 1'b1; m_acc[0] = cyc; m_exp[0] = alu_f(p0_A, p0_B, p0_ctl); m_last = 1'b0;
      end
      if (e_grant[1]) begin
        m_owned[1] = 1'b1; m_acc[1] = cyc; m_exp[1] = alu_f(p1_A, p1_B, p1_ctl); m_last = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; p0_valid = 1'b1; p1_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if ({p1_ready, p0_ready} !== 2'b00) begin n_fail++;
      $display("FAIL reset_ready: got %b expected 00", {p1_ready, p0_ready}); end
    n_cmp++; if ({p1_rsp_valid, p0_rsp_valid} !== 2'b00) begin n_fail++;
      $display("FAIL reset_rsp_valid: got %b expected 00", {p1_rsp_valid, p0_rsp_valid}); end
    n_cmp++; if ({alu_A, alu_B, alu_ctl} !== 39'd0) begin n_fail++;
      $display("FAIL reset_alu: got A=%h B=%h ctl=%h expected 0", alu_A, alu_B, alu_ctl); end
    n_cmp++; if ({p0_rsp_out, p1_rsp_out, conflict_cnt} !== 48'd0) begin n_fail++;
      $display("FAIL reset_data: got %h %h cnt=%h expected 0", p0_rsp_out, p1_rsp_out, conflict_cnt); end
    apply_reset();
  endtask

  task automatic test_basic_add();
    apply_reset();
    p0_valid = 1'b1; p0_A = 16'd5; p0_B = 16'd3; p0_ctl = c_ADD;
    @(negedge clk);
    n_cmp++; if ({p1_ready, p0_ready} !== 2'b01) begin n_fail++;
      $display("FAIL add_grant: got %b expected 01", {p1_ready, p0_ready}); end
    next_cycle(); p0_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({alu_A, alu_B, alu_ctl, p0_rsp_valid} !== {16'd5, 16'd3, c_ADD, 1'b0}) begin n_fail++;
      $display("FAIL add_issue: got A=%0d B=%0d ctl=%h rv=%b expected 5 3 04 0", alu_A, alu_B, alu_ctl, p0_rsp_valid); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({p0_rsp_valid, p0_rsp_out, p0_rsp_ofl, p0_rsp_z} !== {1'b1, 16'd8, 2'b00}) begin n_fail++;
      $display("FAIL add_rsp: got v=%b out=%0d ofl=%b z=%b expected 1 8 0 0", p0_rsp_valid, p0_rsp_out, p0_rsp_ofl, p0_rsp_z); end
    p0_rsp_ready = 1'b1;
    next_cycle(); p0_rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (p0_rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL add_consume: got %b expected 0", p0_rsp_valid); end
  endtask

  task automatic test_ovf_zero();
    logic [15:0] va [2], vb [2], vout [2];
    logic [1:0]  vflag [2];
    va[0] = 16'h7FFF; vb[0] = 16'h0001; vout[0] = 16'h8000; vflag[0] = 2'b10;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vout[1] = 16'h0000; vflag[1] = 2'b01;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      p1_valid = 1'b1; p1_A = va[i]; p1_B = vb[i]; p1_ctl = c_SADD; p1_rsp_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (p1_ready !== 1'b1) begin n_fail++;
        $display("FAIL ovf_grant[%0d]: got %b expected 1", i, p1_ready); end
      next_cycle(); p1_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      n_cmp++; if ({p1_rsp_valid, p1_rsp_out, p1_rsp_ofl, p1_rsp_z} !== {1'b1, vout[i], vflag[i]}) begin n_fail++;
        $display("FAIL ovf_rsp[%0d]: got v=%b out=%h ofl=%b z=%b expected 1 %h %b", i,
                 p1_rsp_valid, p1_rsp_out, p1_rsp_ofl, p1_rsp_z, vout[i], vflag[i]); end
      p1_rsp_ready = 1'b1;
      next_cycle(); p1_rsp_ready = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] pat [6];
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b00; pat[3] = 2'b01; pat[4] = 2'b10; pat[5] = 2'b00;
    apply_reset();
    p0_valid = 1'b1; p1_valid = 1'b1; p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    p0_A = 16'd1; p0_B = 16'd2; p0_ctl = c_ADD; p1_A = 16'd100; p1_B = 16'd4; p1_ctl = c_ADD;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if ({p1_ready, p0_ready} !== pat[c]) begin n_fail++;
        $display("FAIL rr_grant[c%0d]: got %b expected %b", c, {p1_ready, p0_ready}, pat[c]); end
      next_cycle();
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  task automatic test_hold();
    int p1_grants;
    apply_reset();
    p1_grants = 0;
    p0_valid = 1'b1; p0_A = 16'd10; p0_B = 16'd20; p0_ctl = c_ADD; p0_rsp_ready = 1'b0;
    p1_valid = 1'b1; p1_A = 16'd7;  p1_B = 16'd7;  p1_ctl = c_ADD; p1_rsp_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 1 && p1_ready === 1'b1) p1_grants++;
      if (c >= 2) begin
        n_cmp++; if ({p0_ready, p0_rsp_valid, p0_rsp_out} !== {1'b0, 1'b1, 16'd30}) begin n_fail++;
          $display("FAIL hold[c%0d]: got rdy=%b v=%b out=%0d expected 0 1 30", c, p0_ready, p0_rsp_valid, p0_rsp_out); end
      end
      next_cycle();
    end
    n_cmp++; if (p1_grants !== 3) begin n_fail++;
      $display("FAIL hold_p1_served: got %0d grants expected 3", p1_grants); end
    p0_valid = 1'b0; p1_valid = 1'b0; p0_rsp_ready = 1'b1;
    next_cycle(); next_cycle();
    p0_rsp_ready = 1'b0;
  endtask

  task automatic test_flush();
    apply_reset();
    p0_valid = 1'b1; p0_A = 16'd1; p0_B = 16'd2; p0_ctl = c_ADD; p0_rsp_ready = 1'b1;
    next_cycle();
    flush = 1'b1; p1_valid = 1'b1; p1_A = 16'd3; p1_B = 16'd3; p1_ctl = c_ADD;
    @(negedge clk);
    n_cmp++; if ({p1_ready, p0_ready} !== 2'b00) begin n_fail++;
      $display("FAIL flush_no_grant: got %b expected 00", {p1_ready, p0_ready}); end
    next_cycle();
    flush = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (p0_rsp_valid !== 1'b0) begin n_fail++;
        $display("FAIL flush_squash[c%0d]: got %b expected 0", c, p0_rsp_valid); end
      next_cycle();
    end
    p0_valid = 1'b1; p0_A = 16'd4; p0_B = 16'd4;
    @(negedge clk);
    n_cmp++; if (p0_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_regrant: got %b expected 1", p0_ready); end
    next_cycle(); p0_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({p0_rsp_valid, p0_rsp_out} !== {1'b1, 16'd8}) begin n_fail++;
      $display("FAIL flush_after_rsp: got v=%b out=%0d expected 1 8", p0_rsp_valid, p0_rsp_out); end
    next_cycle();
    p0_rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    p0_valid = 1'b1; p0_A = 16'h1234; p0_B = 16'h0101; p0_ctl = c_ADD;
    next_cycle();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({alu_A, alu_B, alu_ctl, p0_ready, p0_rsp_valid} !== 41'd0) begin n_fail++;
      $display("FAIL async_rst: got A=%h B=%h ctl=%h rdy=%b v=%b expected 0", alu_A, alu_B, alu_ctl, p0_ready, p0_rsp_valid); end
    p0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (p0_rsp_valid !== 1'b0) begin n_fail++;
        $display("FAIL async_lost[c%0d]: got %b expected 0", c, p0_rsp_valid); end
      next_cycle();
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_cnt;
`ifdef EXEC_ARB_STATS_EN
    exp_cnt = 16'd4;
`else
    exp_cnt = 16'd0;
`endif
    apply_reset();
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p0_valid = 1'b1; p1_valid = 1'b1;
      next_cycle();
      p0_valid = 1'b0; p1_valid = 1'b0;
      repeat (4) next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (conflict_cnt !== exp_cnt) begin n_fail++;
      $display("FAIL stats_ties: got %0d expected %0d", conflict_cnt, exp_cnt); end
    p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      p0_valid = ($urandom_range(0, 3) != 0); p1_valid = ($urandom_range(0, 3) != 0);
      p0_A = 16'($urandom); p0_B = 16'($urandom); p0_ctl = 7'($urandom);
      p1_A = 16'($urandom); p1_B = 16'($urandom); p1_ctl = 7'($urandom);
      p0_rsp_ready = ($urandom_range(0, 2) != 0); p1_rsp_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      model_eval();
      n_cmp++; if ({p1_ready, p0_ready} !== e_grant) begin n_fail++;
        $display("FAIL rnd_grant[c%0d]: got %b expected %b", c, {p1_ready, p0_ready}, e_grant); end
      n_cmp++; if ({p1_rsp_valid, p0_rsp_valid} !== e_rsp) begin n_fail++;
        $display("FAIL rnd_rsp_valid[c%0d]: got %b expected %b", c, {p1_rsp_valid, p0_rsp_valid}, e_rsp); end
      if (e_rsp[0]) begin
        n_cmp++; if ({p0_rsp_ofl, p0_rsp_z, p0_rsp_out} !== m_exp[0]) begin n_fail++;
          $display("FAIL rnd_p0_data[c%0d]: got %h expected %h", c, {p0_rsp_ofl, p0_rsp_z, p0_rsp_out}, m_exp[0]); end
      end
      if (e_rsp[1]) begin
        n_cmp++; if ({p1_rsp_ofl, p1_rsp_z, p1_rsp_out} !== m_exp[1]) begin n_fail++;
          $display("FAIL rnd_p1_data[c%0d]: got %h expected %h", c, {p1_rsp_ofl, p1_rsp_z, p1_rsp_out}, m_exp[1]); end
      end
      n_cmp++; if (conflict_cnt !== m_cnt) begin n_fail++;
        $display("FAIL rnd_conflict_cnt[c%0d]: got %0d expected %0d", c, conflict_cnt, m_cnt); end
      model_commit();
      next_cycle();
    end
    flush = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_basic_add();
    test_ovf_zero();
    test_round_robin();
    test_hold();
    test_flush();
    test_async_reset();
    test_stats();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
